// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
//   Whole packets are granted to one requester at a time. Packets are ordered
//   round-robin, and an internal byte timer paces the bytes because uart_tx
//   reports neither done nor busy. o_tx_data/o_tx_valid connect directly to
//   the serializer's i_data_tx/i_data_valid.
//
// Configuration macro:
//   UART_ARB_FIXED_PRIO_EN - when defined, the lowest requester index always
//                            wins and the round-robin pointer is removed.
//
// Ports:
//   i_clk_sys   in   system clock (only clock)
//   i_rst       in   synchronous reset, active-high
//   i_req       in   [NUM_REQ]            per-requester "byte available"
//   i_data      in   [NUM_REQ*DATA_WIDTH] byte of requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_last      in   [NUM_REQ]            presented byte ends its packet
//   o_ack       out  [NUM_REQ]            1-cycle pulse: byte of requester k taken
//   o_grant     out  [NUM_REQ]            one-hot UART owner, 0 when idle
//   o_busy      out  arbiter not idle
//   o_tx_data   out  [DATA_WIDTH]         byte to uart_tx, held until next load
//   o_tx_valid  out  1-cycle send strobe to uart_tx
//   o_abort     out  1-cycle pulse: owner dropped i_req mid-packet
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLK_FRE      = 50,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_ON    = 0,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]            i_last,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_valid,
    output logic                          o_abort
);

    // One full frame (start + data + optional parity + stop) plus idle guard.
    localparam int BYTE_CYCLES = (CLK_FRE * 1000000 / BAUD_RATE) * (DATA_WIDTH + 2 + PARITY_ON)
                                 + GUARD_CYCLES;
    localparam int TMR_W = $clog2(BYTE_CYCLES + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BYTE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [IDX_W-1:0]      r_owner, w_owner_next;
    logic [TMR_W-1:0]      r_timer, w_timer_next;
    logic                  r_last, w_last_next;
    logic [NUM_REQ-1:0]    r_grant, w_grant_next;
    logic [NUM_REQ-1:0]    r_ack, w_ack_next;
    logic                  r_busy, w_busy_next;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_next;
    logic                  r_tx_valid, w_tx_valid_next;
    logic                  r_abort, w_abort_next;

    logic                  w_pick_found;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_advance;     // packet over: move the pointer past the owner

    // Per-requester byte lanes.
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_data_arr[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

`ifdef UART_ARB_FIXED_PRIO_EN
    // Lowest set index wins; scanning downwards leaves the lowest one last.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = IDX_W'(i);
            end
        end
    end
`else
    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_owner_inc;

    assign w_owner_inc = (r_owner == IDX_MAX) ? '0 : r_owner + 1'b1;

    // First set request at or after the pointer, wrapping. Offsets are
    // scanned from the far end so the smallest offset is the final winner.
    always_comb begin
        logic [IDX_W:0] w_sum;
        w_sum        = '0;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_sum >= NUM_W) begin
                w_sum = w_sum - NUM_W;
            end
            if (i_req[w_sum[IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_advance) begin
            r_ptr <= w_owner_inc;
        end
    end
`endif

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_timer_next    = r_timer;
        w_last_next     = r_last;
        w_grant_next    = r_grant;
        w_ack_next      = '0;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = 1'b0;
        w_abort_next    = 1'b0;
        w_advance       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_owner_next = w_pick_idx;
                    w_grant_next = NUM_REQ'(1) << w_pick_idx;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_req[r_owner]) begin
                    w_tx_data_next  = w_data_arr[r_owner];
                    w_last_next     = i_last[r_owner];
                    w_tx_valid_next = 1'b1;
                    w_ack_next      = r_grant;
                    w_timer_next    = TMR_LOAD;
                    w_state_next    = S_WAIT;
                end else begin
                    // Owner gave up mid-packet: release without sending.
                    w_abort_next = 1'b1;
                    w_grant_next = '0;
                    w_advance    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_timer == '0) begin
                    if (r_last) begin
                        w_grant_next = '0;
                        w_advance    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            default: begin
                w_grant_next = '0;
                w_state_next = S_IDLE;
            end
        endcase

        // Registered copy of "next state is not idle" keeps o_busy glitch-free
        // and aligned with the state register.
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_timer    <= '0;
            r_last     <= 1'b0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_timer    <= w_timer_next;
            r_last     <= w_last_next;
            r_grant    <= w_grant_next;
            r_ack      <= w_ack_next;
            r_busy     <= w_busy_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_abort    <= w_abort_next;
        end
    end

    assign o_ack      = r_ack;
    assign o_grant    = r_grant;
    assign o_busy     = r_busy;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_abort    = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter with NUM_REQ=2 and a 100-cycle byte time.
// Requesters are modelled as byte queues that advance on o_ack. Every
// o_tx_valid strobe is logged and compared against a packet-level reference:
// packets are chosen round-robin (or lowest index when
// UART_ARB_FIXED_PRIO_EN is defined), the first byte appears 2 cycles after
// the request, bytes inside a packet are BYTE_CYCLES+1 apart and the first
// byte of a following packet is BYTE_CYCLES+2 after the previous byte
// (one extra idle cycle for re-arbitration).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int BC = 100;   // (1*1e6/100000)*(8+2+0)+0

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    i_req  = '0;
    logic [N-1:0]    i_last = '0;
    logic [N*DW-1:0] i_data = '0;
    logic [N-1:0]    o_ack;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic [DW-1:0]   o_tx_data;
    logic            o_tx_valid;
    logic            o_abort;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .CLK_FRE      (1),
        .BAUD_RATE    (100000),
        .DATA_WIDTH   (DW),
        .PARITY_ON    (0),
        .GUARD_CYCLES (0)
    ) dut (
        .i_clk_sys  (clk),
        .i_rst      (rst),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_busy     (o_busy),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_abort    (o_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } byte_t;

    typedef struct {
        int           cyc;
        logic [7:0]   d;
        logic [N-1:0] g;
    } ev_t;

    typedef struct {
        int           off;
        logic [N-1:0] grant;
        logic         busy;
        logic         valid;
        logic [N-1:0] ack;
        logic [7:0]   data;
    } vec_t;

    byte_t src_q [N][$];
    ev_t   log_q [$];
    ev_t   exp_q [$];
    vec_t  tbl   [10];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int stray_ack = 0;
    int abort_cnt = 0;
    int last_abort_cyc = -1;
    int m_ptr = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit q_empty();
        for (int k = 0; k < N; k++) if (src_q[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Present the head of each requester queue; i_req follows queue occupancy.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                i_req[k]           = 1'b1;
                i_data[k*DW +: DW] = src_q[k][0].b;
                i_last[k]          = src_q[k][0].l;
            end else begin
                i_req[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (o_tx_valid === 1'b1) begin
            log_q.push_back('{cyc, o_tx_data, o_grant});
            $display("tx cyc=%0d grant=%b ack=%b data=%02h", cyc, o_grant, o_ack, o_tx_data);
            check_eq("ack_with_valid", 64'(o_ack), 64'(o_grant));
        end else if (!rst && o_ack !== '0) begin
            stray_ack++;
        end
        if (o_abort === 1'b1) begin
            abort_cnt++;
            last_abort_cyc = cyc;
            $display("abort cyc=%0d", cyc);
        end
        for (int k = 0; k < N; k++)
            if (o_ack[k] === 1'b1 && src_q[k].size() > 0) void'(src_q[k].pop_front());
        drive();
    endtask

    // Packet-level reference: which requester sends which byte, and when.
    task automatic build_model(input int t0);
        byte_t        cp [N][$];
        int           t;
        bit           first;
        int           pick;
        int           j;
        bit           done;
        bit           newpkt;
        byte_t        bb;
        logic [N-1:0] oh;
        for (int k = 0; k < N; k++) cp[k] = src_q[k];
        exp_q.delete();
        t = t0 + 2;
        first = 1'b1;
        forever begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
                j = i;
`else
                j = (m_ptr + i) % N;
`endif
                if (pick < 0 && cp[j].size() > 0) pick = j;
            end
            if (pick < 0) break;
            done = 1'b0;
            newpkt = 1'b1;
            oh = '0;
            oh[pick] = 1'b1;
            while (!done) begin
                bb = cp[pick].pop_front();
                if (!first) t += newpkt ? (BC + 2) : (BC + 1);
                first = 1'b0;
                newpkt = 1'b0;
                exp_q.push_back('{t, bb.b, oh});
                done = bb.l || (cp[pick].size() == 0);
            end
            m_ptr = (pick + 1) % N;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (n < budget && !(q_empty() && o_busy === 1'b0));
        if (n >= budget) check_eq({name, "_timeout"}, 64'(n), 64'(budget - 1));
    endtask

    task automatic compare_log(input string name);
        check_eq({name, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_eq($sformatf("%s_ev%0d", name, i),
                     {32'(log_q[i].cyc), log_q[i].d, log_q[i].g},
                     {32'(exp_q[i].cyc), exp_q[i].d, exp_q[i].g});
    endtask

    task automatic run_scen(input string name);
        int t0;
        log_q.delete();
        drive();
        t0 = cyc;
        build_model(t0);
        wait_idle(exp_q.size() * (BC + 3) + BC + 20, name);
        compare_log(name);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int v;
        int n;

        // Expected trace for a 3-byte packet on req0 requested at offset 0.
        tbl[0] = '{0,   2'b00, 1'b0, 1'b0, 2'b00, 8'h5A};
        tbl[1] = '{1,   2'b01, 1'b1, 1'b0, 2'b00, 8'h5A};
        tbl[2] = '{2,   2'b01, 1'b1, 1'b1, 2'b01, 8'h41};
        tbl[3] = '{3,   2'b01, 1'b1, 1'b0, 2'b00, 8'h41};
        tbl[4] = '{102, 2'b01, 1'b1, 1'b0, 2'b00, 8'h41};
        tbl[5] = '{103, 2'b01, 1'b1, 1'b1, 2'b01, 8'h54};
        tbl[6] = '{104, 2'b01, 1'b1, 1'b0, 2'b00, 8'h54};
        tbl[7] = '{204, 2'b01, 1'b1, 1'b1, 2'b01, 8'h0D};
        tbl[8] = '{303, 2'b01, 1'b1, 1'b0, 2'b00, 8'h0D};
        tbl[9] = '{304, 2'b00, 1'b0, 1'b0, 2'b00, 8'h0D};

        // Reset held 2 cycles with both requesting.
        rst = 1'b1;
        src_q[0].push_back('{8'hA5, 1'b1});
        src_q[1].push_back('{8'h5A, 1'b1});
        drive();
        step();
        check_eq("reset_outs_1", {o_ack, o_grant, o_busy, o_tx_data, o_tx_valid, o_abort}, '0);
        step();
        check_eq("reset_outs_2", {o_ack, o_grant, o_busy, o_tx_data, o_tx_valid, o_abort}, '0);
        rst = 1'b0;
        stray_ack = 0;
        abort_cnt = 0;
        m_ptr = 0;
        log_q.delete();
        t0 = cyc;
        build_model(t0);
        check_eq("release_grant_c1", 64'(o_grant), 64'(2'b00));
        step();
        check_eq("release_grant_c2", 64'(o_grant), 64'(2'b01));
        wait_idle(400, "t1");
        compare_log("t1");

        // 3-byte packet on req0, cycle-exact trace.
        log_q.delete();
        src_q[0].push_back('{8'h41, 1'b0});
        src_q[0].push_back('{8'h54, 1'b0});
        src_q[0].push_back('{8'h0D, 1'b1});
        drive();
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            while (cyc - t0 < tbl[i].off) step();
            check_eq($sformatf("t2_vec%0d", i),
                     {o_grant, o_busy, o_tx_valid, o_ack, o_tx_data},
                     {tbl[i].grant, tbl[i].busy, tbl[i].valid, tbl[i].ack, tbl[i].data});
        end
        m_ptr = 1;

        // Repeated single-byte packets from req1 alone.
        for (int i = 0; i < 4; i++) src_q[1].push_back('{8'hFF, 1'b1});
        run_scen("t6");

        // Both requesters hold 2-byte packets continuously.
        src_q[0].push_back('{8'hA0, 1'b0}); src_q[0].push_back('{8'hA1, 1'b1});
        src_q[0].push_back('{8'hA2, 1'b0}); src_q[0].push_back('{8'hA3, 1'b1});
        src_q[1].push_back('{8'hB0, 1'b0}); src_q[1].push_back('{8'hB1, 1'b1});
        src_q[1].push_back('{8'hB2, 1'b0}); src_q[1].push_back('{8'hB3, 1'b1});
        run_scen("t3");

        // Abort: req1 drops i_req after a non-last byte.
        log_q.delete();
        abort_cnt = 0;
        src_q[1].push_back('{8'h11, 1'b0});
        drive();
        n = 0;
        while (log_q.size() == 0 && n < 20) begin step(); n++; end
        if (log_q.size() == 0) begin
            check_eq("t4_first_byte", 64'(0), 64'(1));
            v = cyc;
        end else begin
            check_eq("t4_first_byte", {log_q[0].d, log_q[0].g}, {8'h11, 2'b10});
            v = log_q[0].cyc;
        end
        src_q[0].push_back('{8'h22, 1'b1});
        drive();
        n = 0;
        while (abort_cnt == 0 && n < 200) begin step(); n++; end
        check_eq("t4_abort_cyc", 64'(last_abort_cyc), 64'(v + BC + 1));
        check_eq("t4_abort_outs", {o_grant, o_busy, o_tx_valid}, {2'b00, 1'b0, 1'b0});
        check_eq("t4_no_resend", 64'(log_q.size()), 64'(1));
        src_q[1].push_back('{8'h33, 1'b1});
        drive();
        n = 0;
        while (log_q.size() < 2 && n < 10) begin step(); n++; end
        if (log_q.size() >= 2)
            check_eq("t4_next_grant", {32'(log_q[1].cyc), log_q[1].d, log_q[1].g},
                     {32'(v + BC + 3), 8'h22, 2'b01});
        else
            check_eq("t4_next_grant", 64'(log_q.size()), 64'(2));
        wait_idle(300, "t4");
        check_eq("t4_count", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3)
            check_eq("t4_req1_again", {32'(log_q[2].cyc), log_q[2].d, log_q[2].g},
                     {32'(v + 2*BC + 5), 8'h33, 2'b10});
        check_eq("t4_abort_once", 64'(abort_cnt), 64'(1));
        m_ptr = 0;

        // Reset in the middle of the second byte's WAIT.
        log_q.delete();
        src_q[0].push_back('{8'h61, 1'b1});
        src_q[1].push_back('{8'h71, 1'b0});
        src_q[1].push_back('{8'h72, 1'b0});
        src_q[1].push_back('{8'h73, 1'b1});
        drive();
        n = 0;
        while (log_q.size() < 3 && n < 500) begin step(); n++; end
        check_eq("t5_pre_bytes", 64'(log_q.size()), 64'(3));
        for (int i = 0; i < 50; i++) step();
        abort_cnt = 0;
        rst = 1'b1;
        src_q[0].push_back('{8'h62, 1'b1});
        step();
        check_eq("t5_reset_outs", {o_busy, o_grant, o_abort, o_tx_valid, o_ack}, '0);
        rst = 1'b0;
        step();
        check_eq("t5_regrant_req0", 64'(o_grant), 64'(2'b01));
        wait_idle(500, "t5");
        check_eq("t5_no_abort", 64'(abort_cnt), 64'(0));
        m_ptr = 0;

        // Randomized packet mixes against the reference model.
        for (int r = 0; r < 4; r++) begin
            int mask;
            int np;
            int len;
            mask = int'($urandom_range(1, 3));
            for (int k = 0; k < N; k++) begin
                if (mask[k]) begin
                    np = int'($urandom_range(1, 3));
                    for (int p = 0; p < np; p++) begin
                        len = int'($urandom_range(1, 3));
                        for (int b = 0; b < len; b++)
                            src_q[k].push_back('{8'($urandom), (b == len - 1)});
                    end
                end
            end
            run_scen($sformatf("rnd%0d", r));
        end

        check_eq("no_stray_ack", 64'(stray_ack), 64'(0));
        check_eq("no_late_abort", 64'(abort_cnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
